// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the fetch stage and its control decoder.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          DEPTH_DEF    = 2;

    // Instruction field positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int FN_MSB  = 5;
    localparam int FN_LSB  = 0;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;
    localparam int FN_W    = FN_MSB - FN_LSB + 1;

    // One buffered fetch: {pc, instr}
    localparam int ENTRY_W = 64;

    typedef enum logic [OPC_W-1:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Memory request/response, redirect and decode-side handshake of the fetch stage.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [31:0]       imem_req_addr;
    logic              imem_resp_valid;
    logic [31:0]       imem_resp_data;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [31:0]       out_pc;
    logic [OPC_W-1:0]  out_opcode;
    logic [FN_W-1:0]   out_funct;

    // Fetch stage side
    modport master (
        output imem_req_valid, imem_req_addr,
        output out_valid, out_instr, out_pc, out_opcode, out_funct,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc, out_ready
    );

    // Memory / decode side
    modport slave (
        input  imem_req_valid, imem_req_addr,
        input  out_valid, out_instr, out_pc, out_opcode, out_funct,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small FIFO of fetched {pc, instr} entries with flush; read data is 0 when empty.
module fetch_fifo
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = ENTRY_W,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pop on empty is ignored; push is guarded even though credit prevents overflow
    assign do_push = push && !flush && (count != CW'(DEPTH));
    assign do_pop  = pop && !flush && (count != '0);

    // Storage write, no reset needed: contents are qualified by count
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= wdata;
    end

    // Pointers and occupancy; flush empties the buffer
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= bump(wptr);
            if (do_pop)  rptr <= bump(rptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = (count != '0) ? mem[rptr] : '0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: credit-limited requests, in-order response buffering, redirect flush.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int UW = CW + 2;

    logic [31:0]   pc_q;
    logic [CW-1:0] outst_q;    // accepted, response not yet seen
    logic [CW-1:0] drop_q;     // responses still owed by flushed requests
    logic [CW-1:0] fifo_cnt;
    logic [UW-1:0] used;
    logic          accept, drop_hit, push, pop, out_valid;
    fetch_entry_t  wr_e, rd_e;

    // Dropped responses still occupy memory slots, so they hold credit
    assign used   = UW'(outst_q) + UW'(drop_q) + UW'(fifo_cnt);
    assign bus.imem_req_valid = rst_n && !bus.redirect_valid && (used < UW'(DEPTH));
    assign bus.imem_req_addr  = pc_q;
    assign accept = bus.imem_req_valid && bus.imem_req_ready;

    // A response in the redirect cycle is dropped too (accounted in drop_q update)
    assign drop_hit = bus.imem_resp_valid && (drop_q != '0);
    assign push     = bus.imem_resp_valid && !drop_hit && !bus.redirect_valid;
    assign out_valid = (fifo_cnt != '0);
    assign pop       = out_valid && bus.out_ready;

    // Requests since the last redirect are contiguous, so the oldest live one
    // sits outst_q words behind the PC
    always_comb begin
        wr_e       = '0;
        wr_e.pc    = pc_q - (32'(outst_q) << 2);
        wr_e.instr = bus.imem_resp_data;
    end

    // PC: redirect target wins over sequential advance
    always_ff @(posedge clk) begin
        if (!rst_n)
            pc_q <= RESET_PC;
        else if (bus.redirect_valid)
            pc_q <= align_word(bus.redirect_pc);
        else if (accept)
            pc_q <= pc_q + 32'd4;
    end

    // In-flight accounting: redirect moves all live requests into the drop count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outst_q <= '0;
            drop_q  <= '0;
        end else if (bus.redirect_valid) begin
            outst_q <= '0;
            drop_q  <= drop_q + outst_q + CW'(accept) - CW'(bus.imem_resp_valid);
        end else begin
            outst_q <= outst_q + CW'(accept) - CW'(push);
            drop_q  <= drop_q - CW'(drop_hit);
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata (wr_e),
        .rdata (rd_e),
        .count (fifo_cnt)
    );

    assign bus.out_valid  = out_valid;
    assign bus.out_instr  = rd_e.instr;
    assign bus.out_pc     = rd_e.pc;
    assign bus.out_opcode = rd_e.instr[OPC_MSB:OPC_LSB];
    assign bus.out_funct  = rd_e.instr[FN_MSB:FN_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: fixed-latency memory model, logs of issued/popped fetches.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_stage_if bus ();
    fetch_stage_if bus2 ();

    fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.master)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA5C3_0F69;
    endfunction

    // Memory for dut: response appears lat cycles after acceptance
    int          lat = 1;
    logic        pv [8];
    logic [31:0] pa [8];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                pv[i] <= 1'b0;
                pa[i] <= '0;
            end
        end else begin
            for (int i = 7; i > 0; i--) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
            pv[0] <= bus.imem_req_valid && bus.imem_req_ready;
            pa[0] <= bus.imem_req_addr;
        end
    end
    assign bus.imem_resp_valid = pv[lat-1];
    assign bus.imem_resp_data  = memf(pa[lat-1]);

    // Memory for dut2: always ready, one cycle latency
    logic        r2v;
    logic [31:0] r2a;
    always @(posedge clk) begin
        if (!rst_n) begin
            r2v <= 1'b0;
            r2a <= '0;
        end else begin
            r2v <= bus2.imem_req_valid && bus2.imem_req_ready;
            r2a <= bus2.imem_req_addr;
        end
    end
    assign bus2.imem_resp_valid = r2v;
    assign bus2.imem_resp_data  = memf(r2a);

    // Logs of accepted requests and consumed instructions
    logic [31:0] iss[$];
    logic [31:0] pops[$];
    logic [31:0] popi[$];
    logic [31:0] pops2[$];
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.imem_req_valid && bus.imem_req_ready) iss.push_back(bus.imem_req_addr);
            if (bus.out_valid && bus.out_ready) begin
                pops.push_back(bus.out_pc);
                popi.push_back(bus.out_instr);
            end
            if (bus2.out_valid && bus2.out_ready) pops2.push_back(bus2.out_pc);
        end
    end

    int npass = 0;
    int nfail = 0;
    int ntot  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Two reset edges, then release at a falling edge (that cycle is cycle 0)
    task automatic do_reset(input logic ordy);
        rst_n = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = ordy;
        cyc(2);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int p0, b0;
        logic [31:0] e;

        rst_n = 1'b0;
        bus.imem_req_ready  = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.out_ready       = 1'b1;
        bus2.imem_req_ready = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = '0;
        bus2.out_ready      = 1'b1;
        cyc(2);

        // Reset state
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_req_addr", bus.imem_req_addr, 32'h0);
        chk("rst_out_pc", bus.out_pc, 32'h0);
        chk("rst2_req_addr", bus2.imem_req_addr, 32'hFFFF_FFF8);
        chk("rst2_out_valid", 32'(bus2.out_valid), 32'd0);

        // Basic stream, 1-cycle memory
        rst_n = 1'b1;
        #1;
        chk("a_c0_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("a_c0_req_addr", bus.imem_req_addr, 32'h0);
        chk("a_c0_out_valid", 32'(bus.out_valid), 32'd0);
        cyc(1);
        chk("a_c1_out_valid", 32'(bus.out_valid), 32'd0);
        chk("a_c1_req_addr", bus.imem_req_addr, 32'h4);
        cyc(1);
        e = memf(32'h0);
        chk("a_c2_out_valid", 32'(bus.out_valid), 32'd1);
        chk("a_c2_out_pc", bus.out_pc, 32'h0);
        chk("a_c2_out_instr", bus.out_instr, e);
        chk("a_c2_opcode", 32'(bus.out_opcode), 32'(e[31:26]));
        chk("a_c2_funct", 32'(bus.out_funct), 32'(e[5:0]));
        chk("a_c2_req_valid", 32'(bus.imem_req_valid), 32'd0);
        cyc(1);
        chk("a_c3_out_pc", bus.out_pc, 32'h4);
        chk("a_c3_req_addr", bus.imem_req_addr, 32'h8);
        cyc(2);
        chk("a_c5_out_valid", 32'(bus.out_valid), 32'd1);
        chk("a_c5_out_pc", bus.out_pc, 32'h8);
        cyc(3);
        chk("wrap_pc0", pops2[0], 32'hFFFF_FFF8);
        chk("wrap_pc1", pops2[1], 32'hFFFF_FFFC);
        chk("wrap_pc2", pops2[2], 32'h0000_0000);

        // Decode stalled: credit limits requests to DEPTH, then resumes in order
        do_reset(1'b0);
        b0 = iss.size();
        p0 = pops.size();
        cyc(10);
        chk("b_issued", 32'(iss.size() - b0), 32'd2);
        chk("b_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("b_out_pc", bus.out_pc, 32'h0);
        bus.out_ready = 1'b1;
        cyc(12);
        chk("b_pop0", pops[p0],   32'h0);
        chk("b_pop1", pops[p0+1], 32'h4);
        chk("b_pop2", pops[p0+2], 32'h8);
        chk("b_pop3", pops[p0+3], 32'hC);
        chk("b_instr3", popi[p0+3], memf(32'hC));

        // Latency 3, redirect with two requests in flight
        lat = 3;
        do_reset(1'b1);
        p0 = pops.size();
        cyc(2);
        chk("c_req_valid_full", 32'(bus.imem_req_valid), 32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        cyc(1);
        bus.redirect_valid = 1'b0;
        #1;
        chk("c_out_valid", 32'(bus.out_valid), 32'd0);
        chk("c_req_addr", bus.imem_req_addr, 32'h40);
        chk("c_req_valid_drop", 32'(bus.imem_req_valid), 32'd0);
        cyc(1);
        chk("c_req_valid_resume", 32'(bus.imem_req_valid), 32'd1);
        cyc(8);
        chk("c_first_pop", pops[p0], 32'h40);
        chk("c_first_instr", popi[p0], memf(32'h40));

        // Unaligned redirect target mid-stream
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h43;
        cyc(1);
        bus.redirect_valid = 1'b0;
        #1;
        p0 = pops.size();
        chk("d_req_addr", bus.imem_req_addr, 32'h40);
        chk("d_out_valid", 32'(bus.out_valid), 32'd0);
        cyc(12);
        chk("d_first_pop", pops[p0], 32'h40);

        // Back-to-back redirects: last target wins
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        cyc(1);
        bus.redirect_pc    = 32'h200;
        cyc(1);
        bus.redirect_valid = 1'b0;
        #1;
        p0 = pops.size();
        chk("e_req_addr", bus.imem_req_addr, 32'h200);
        chk("e_out_valid", 32'(bus.out_valid), 32'd0);
        cyc(12);
        chk("e_first_pop", pops[p0], 32'h200);
        chk("e_first_instr", popi[p0], memf(32'h200));
        chk("e_second_pop", pops[p0+1], 32'h204);

        // Reset mid-stream with one buffered and one outstanding
        lat = 1;
        do_reset(1'b0);
        cyc(2);
        chk("f_pre_out_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        cyc(1);
        chk("f_out_valid", 32'(bus.out_valid), 32'd0);
        chk("f_req_addr", bus.imem_req_addr, 32'h0);
        chk("f_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("f_out_pc", bus.out_pc, 32'h0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        p0 = pops.size();
        cyc(8);
        chk("f_pop0", pops[p0],   32'h0);
        chk("f_pop1", pops[p0+1], 32'h4);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter DEPTH, default 2, instruction buffer entries; also the maximum number of outstanding memory requests plus buffered instructions.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts request.
REQ-007 imem_req_addr  output  32  word-aligned fetch address.
REQ-008 imem_resp_valid  input  1  response data valid; in order; no backpressure.
REQ-009 imem_resp_data  input  32  fetched instruction.
REQ-010 redirect_valid  input  1  branch taken (control branch AND ALU zero); flush and refetch.
REQ-011 redirect_pc  input  32  branch target.
REQ-012 out_valid  output  1  instruction available to decode/control.
REQ-013 out_ready  input  1  decode consumes instruction.
REQ-014 out_instr  output  32  head instruction.
REQ-015 out_pc  output  32  address of out_instr.
REQ-016 out_opcode  output  6  out_instr[31:26].
REQ-017 out_funct  output  6  out_instr[5:0].

Function
REQ-018 Request transfer occurs when imem_req_valid and imem_req_ready are both high; the PC then advances by 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-019 imem_req_valid is high iff (outstanding + buffer occupancy) < DEPTH and redirect_valid is low; it may be high while imem_req_ready is low.
REQ-020 imem_req_addr equals the PC register and holds stable while imem_req_valid is high and imem_req_ready is low.
REQ-021 Each accepted request increments outstanding; each non-dropped response decrements outstanding and pushes {pc, data} into the buffer; a simultaneous accept and response leaves outstanding unchanged.
REQ-022 The response PC is tracked per request, in order, inside the buffer reservation; out_pc matches the request address of out_instr.
REQ-023 The buffer is a FIFO; out_valid is high iff occupancy > 0; a pop occurs when out_valid and out_ready are both high.
REQ-024 A push and pop in the same cycle leaves occupancy unchanged. Overflow is impossible by construction (REQ-019); pop when empty is ignored.
REQ-025 Minimum latency: request accepted in cycle N, response in cycle N+1, out_valid in cycle N+2 (registered, no bypass).
REQ-026 On redirect_valid: PC is set to {redirect_pc[31:2],2'b00}; the buffer is emptied; drop_cnt is set to outstanding (including a request accepted that cycle, if any); outstanding is set to 0; out_valid is low the next cycle.
REQ-027 While drop_cnt > 0, each response is discarded and decrements drop_cnt; these responses consume credit, so REQ-019 counts drop_cnt as outstanding.
REQ-028 A response arriving in the same cycle as redirect_valid is discarded and counts against drop_cnt.
REQ-029 Redirect has priority over push; an out handshake in the redirect cycle still completes (the branch itself is consumed).
REQ-030 Back-to-back redirects are each honoured; the last one wins the PC.
REQ-031 out_opcode and out_funct are combinational slices of out_instr.

Reset
REQ-032 While rst_n is low at a clock edge: PC=RESET_PC; occupancy, outstanding and drop_cnt = 0; imem_req_valid=0; out_valid=0.
REQ-033 Reset mid-operation abandons in-flight requests; the memory is also reset by the same rst_n, so no stale responses arrive.
REQ-034 The data outputs (out_instr, out_pc) are don't-care while out_valid is low; a stable 0 is preferred.

Structure
REQ-035 The shared package holds RESET_PC default, DEPTH default, the opcode/funct bit positions, and the opcode constants used by the control decoder.
REQ-036 One sub-module, fetch_fifo (parameterised DEPTH, width 64, push/pop/flush, count output).

Verification
REQ-037 Reset then imem_req_ready=1, 1-cycle memory: addresses 0,4,8 issued; out_valid first at cycle 2 after reset release; out_pc=0, out_instr=mem[0].
REQ-038 out_ready=0 for 10 cycles: exactly DEPTH requests are issued, then imem_req_valid=0; on out_ready=1, fetch resumes in order without loss.
REQ-039 Memory latency 3 with redirect_pc=32'h40 while 2 requests are in flight: 2 responses are dropped; the next out_pc=32'h40.
REQ-040 redirect_pc=32'h43: fetch starts at 32'h40.
REQ-041 RESET_PC=32'hFFFF_FFF8: fetches 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0.
REQ-042 rst_n low mid-stream with 1 buffered and 1 outstanding: next cycle out_valid=0, imem_req_addr=RESET_PC.
